// File: rtl/systolic_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | systolic_ctrl: job sequencer for the N1xN2 systolic matrix-multiply array |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module systolic_ctrl #(
    parameter int D_W_ACC = 16,
    parameter int N1      = 4,
    parameter int N2      = 4,
    parameter int M       = 8,
    parameter int TIMEOUT = 256,
    localparam int FEED   = (M * M * M) / (N1 * N2),
    localparam int RES    = (M * M) / N1,
    localparam int AW     = (RES > 1) ? $clog2(RES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             cycle_cnt,
    output logic                    enable_row_count_A,
    input  logic [N1*D_W_ACC-1:0]   D,
    input  logic [N1-1:0]           valid_D,
    output logic [N1-1:0]           wr_en_C,
    output logic [N1*AW-1:0]        wr_addr_C,
    output logic [N1*D_W_ACC-1:0]   wr_data_C
);

    localparam int FW = (FEED > 1) ? $clog2(FEED) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CW = $clog2(RES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [FW-1:0] feed_q, feed_d;
    logic [TW-1:0] drain_q, drain_d;
    logic [15:0]   cyc_q;
    logic          err_q;
    logic          busy_q, busy_d;
    logic          en_q, en_d;
    logic          done_q, done_d;

    logic          w_accept;
    logic          w_collect;
    logic          w_all_full;
    logic          w_timeout;
    logic [N1-1:0] w_full;
    logic [N1-1:0] w_ovf;

    assign w_accept   = (state_q == S_IDLE) && start && !abort;
    assign w_collect  = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign w_all_full = &w_full;
    assign w_timeout  = (state_q == S_DRAIN) && !abort && !w_all_full
                        && (drain_q == TW'(TIMEOUT - 1));

    // State register, with the output registers it drives
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) state_d = S_FEED;
            end
            S_FEED: begin
                if (abort)                          state_d = S_IDLE;
                else if (feed_q == FW'(FEED - 1))   state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                          state_d = S_IDLE;
                else if (w_all_full || w_timeout)   state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they are registered alongside it
    always_comb begin
        busy_d = 1'b0;
        en_d   = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_FEED:  begin busy_d = 1'b1; en_d = 1'b1; end
            S_DRAIN: busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        feed_d  = '0;
        drain_d = '0;
        if (state_q == S_FEED)  feed_d  = feed_q + FW'(1);
        if (state_q == S_DRAIN) drain_d = drain_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            feed_q  <= '0;
            drain_q <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            feed_q  <= feed_d;
            drain_q <= drain_d;
            if (w_accept) begin
                cyc_q <= '0;
                err_q <= 1'b0;
            end else begin
                if (w_collect && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
                if (w_timeout || |w_ovf)            err_q <= 1'b1;
            end
        end
    end

    // Per-row result collection; rows never interact
    for (genvar i = 0; i < N1; i++) begin : g_row
        logic [CW-1:0]      cnt_q;
        logic               wen_q;
        logic [AW-1:0]      addr_q;
        logic [D_W_ACC-1:0] data_q;
        logic               w_room;
        logic               w_take;

        assign w_room    = (cnt_q < CW'(RES));
        assign w_take    = w_collect && valid_D[i] && w_room;
        assign w_full[i] = !w_room;
        assign w_ovf[i]  = w_collect && valid_D[i] && !w_room;

        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q  <= '0;
                wen_q  <= 1'b0;
                addr_q <= '0;
                data_q <= '0;
            end else begin
                wen_q <= w_take;
                if (w_take) begin
                    cnt_q  <= cnt_q + CW'(1);
                    addr_q <= cnt_q[AW-1:0];
                    data_q <= D[i*D_W_ACC +: D_W_ACC];
                end else if (state_q == S_IDLE) begin
                    cnt_q <= '0;
                end
            end
        end

        assign wr_en_C[i]                       = wen_q;
        assign wr_addr_C[i*AW +: AW]            = addr_q;
        assign wr_data_C[i*D_W_ACC +: D_W_ACC]  = data_q;
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign cycle_cnt          = cyc_q;
    assign enable_row_count_A = en_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_systolic_ctrl: scoreboard bench for systolic_ctrl (default parameters) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_systolic_ctrl;

    localparam int N1  = 4;
    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int RES = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, err, en_a;
    logic [15:0]       cycle_cnt;
    logic [N1*DW-1:0]  D = '0;
    logic [N1-1:0]     valid_D = '0;
    logic [N1-1:0]     wr_en_C;
    logic [N1*AW-1:0]  wr_addr_C;
    logic [N1*DW-1:0]  wr_data_C;

    systolic_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .cycle_cnt          (cycle_cnt),
        .enable_row_count_A (en_a),
        .D                  (D),
        .valid_D            (valid_D),
        .wr_en_C            (wr_en_C),
        .wr_addr_C          (wr_addr_C),
        .wr_data_C          (wr_data_C)
    );

    always #5 clk = ~clk;

    typedef struct { int row; int addr; int data; } wr_t;
    typedef struct { bit err; int cyc; } dn_t;

    wr_t exp_wr[$];
    dn_t exp_dn[$];

    int n_tests = 0;
    int n_fail  = 0;
    int en_total = 0;
    int done_total = 0;
    int cfg_first[N1];
    int cfg_nb[N1];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes / completions whenever the DUT presents them
    always @(negedge clk) begin
        if (en_a) en_total++;
        for (int i = 0; i < N1; i++) begin
            if (wr_en_C[i]) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", wr_en_C[i], 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_row",  i, e.row);
                    check("wr_addr", wr_addr_C[i*AW +: AW], e.addr);
                    check("wr_data", wr_data_C[i*DW +: DW], e.data);
                end
            end
        end
        if (done) begin
            done_total++;
            if (exp_dn.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                dn_t d;
                d = exp_dn.pop_front();
                check("done_err", err, d.err);
                check("done_cycle_cnt", cycle_cnt, d.cyc);
                check("done_busy", busy, 0);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_en"}, en_a, 0);
        check({tag, "_wr_en"}, wr_en_C, 0);
        check({tag, "_cycle_cnt"}, cycle_cnt, 0);
        check({tag, "_wr_addr"}, wr_addr_C, 0);
        check({tag, "_wr_data"}, wr_data_C, 0);
    endtask

    // One job: row i delivers cfg_nb[i] beats starting at job cycle cfg_first[i]
    task automatic run_job(input int max_r, input int stop_r, input int abort_r,
                           input int rst_r, input bit spulse, input bit exp_done,
                           input bit exp_err, input int exp_cyc, input int exp_en);
        int en0, d0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_on_accept", busy, 1);
        en0 = en_total;
        d0  = done_total;
        if (exp_done) exp_dn.push_back('{err: exp_err, cyc: exp_cyc});
        for (int r = 0; r < max_r; r++) begin
            valid_D = '0;
            D       = '0;
            abort   = (r == abort_r);
            rst     = (r == rst_r) ? 1'b0 : 1'b1;
            start   = spulse && (r == 5 || r == 35);
            if (r <= stop_r) begin
                for (int i = 0; i < N1; i++) begin
                    int k;
                    k = r - cfg_first[i];
                    if (k >= 0 && k < cfg_nb[i]) begin
                        valid_D[i]        = 1'b1;
                        D[i*DW +: DW]     = 16'(i * 100 + k);
                        if (k < RES) exp_wr.push_back('{row: i, addr: k, data: i * 100 + k});
                    end
                end
            end
            @(posedge clk); #1;
            if (r == abort_r) begin
                check("abort_busy", busy, 0);
                check("abort_en", en_a, 0);
            end
            if (r == rst_r) check_reset_values("midreset");
            if (done_total != d0) break;
        end
        valid_D = '0;
        D       = '0;
        abort   = 1'b0;
        start   = 1'b0;
        rst     = 1'b1;
        check("done_pulses", done_total - d0, exp_done ? 1 : 0);
        check("enable_cycles", en_total - en0, exp_en);
    endtask

    task automatic nominal_cfg();
        for (int i = 0; i < N1; i++) begin
            cfg_first[i] = 8 * i;
            cfg_nb[i]    = RES;
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Nominal job, with stray start pulses in FEED and DRAIN
        nominal_cfg();
        run_job(100, 100, -1, -1, 1'b1, 1'b1, 1'b0, 41, 32);

        // start and abort together in IDLE, then valid_D while idle
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", busy, 0);
        valid_D = '1;
        D       = {16'd7, 16'd7, 16'd7, 16'd7};
        repeat (3) @(posedge clk);
        #1;
        valid_D = '0;
        check("idle_valid_wr_en", wr_en_C, 0);
        check("idle_valid_err", err, 0);
        @(posedge clk); #1;

        // Overflow: 17th beat on row 0
        nominal_cfg();
        cfg_nb[0] = RES + 1;
        run_job(100, 100, -1, -1, 1'b0, 1'b1, 1'b1, 41, 32);

        // Abort at feed cycle 10
        nominal_cfg();
        run_job(20, 10, 10, -1, 1'b0, 1'b0, 1'b0, 0, 11);

        // Clean job after abort: err cleared, cycle_cnt restarted
        nominal_cfg();
        run_job(100, 100, -1, -1, 1'b0, 1'b1, 1'b0, 41, 32);

        // Timeout: row 2 short by one result
        nominal_cfg();
        cfg_nb[2] = RES - 1;
        run_job(320, 320, -1, -1, 1'b0, 1'b1, 1'b1, 288, 32);

        // Reset pulse while in DRAIN
        nominal_cfg();
        cfg_nb[2] = RES - 1;
        run_job(55, 49, -1, 50, 1'b0, 1'b0, 1'b0, 0, 32);

        // Fresh job after the reset
        nominal_cfg();
        run_job(100, 100, -1, -1, 1'b0, 1'b1, 1'b0, 41, 32);

        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", exp_wr.size(), 0);
        check("pending_dones", exp_dn.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
